rand_req_host: RTL

- Initiator side of the byte-serial CPU random-number interface (rand_req / rand_req_type / rand_byte / rand_valid).
- Accepts a command from a host or bench-side controller (FPGA harness, CPU model), then drives rand_req and rand_req_type.
- Collects the returned bytes little-endian into a 64-bit word and returns it with a success flag.
- Aborts with a failure response, in the style of RDRAND/RDSEED CF=0, if the responder stalls.

---
 rtl/rand_req_host_pkg.sv | 38 +++
 rtl/rand_req_host_assembler.sv | 45 ++++
 rtl/rand_req_host.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/rand_req_host_pkg.sv
// Shared types for the byte-serial random-number request host: request encoding,
// FSM states, default timing parameters and the byte-count helper.
package rand_req_host_pkg;

  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;
  localparam int DEFAULT_GAP_CYCLES     = 1;

  typedef enum logic [1:0] {
    SIZE_16   = 2'd0,
    SIZE_32   = 2'd1,
    SIZE_64   = 2'd2,
    SIZE_RSVD = 2'd3
  } req_size_e;

  // bit2 selects RDSEED (1) or RDRAND (0); bits1:0 carry the size code.
  typedef struct packed {
    logic      seed;
    req_size_e size;
  } rand_req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_GAP
  } state_e;

  // Returns 0 for the reserved size so callers can reject it without a request.
  function automatic logic [3:0] req_bytes(input req_size_e size);
    case (size)
      SIZE_16: return 4'd2;
      SIZE_32: return 4'd4;
      SIZE_64: return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/rand_req_host_assembler.sv
// Little-endian byte collector: writes each captured byte into the next lane of a
// 64-bit word and flags the capture that completes the requested byte count.
module rand_byte_assembler (
  input  logic        clk,
  input  logic        srst,
  input  logic        clear,
  input  logic        capture,
  input  logic [7:0]  byte_in,
  input  logic [3:0]  nbytes,
  output logic [63:0] data,
  output logic        last
);

  logic [3:0] idx_reg;
  logic       room;

  // The index saturates at nbytes; captures beyond that are dropped.
  assign room = idx_reg < nbytes;
  assign last = capture && room && ((idx_reg + 4'd1) == nbytes);

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      idx_reg <= 4'd0;
    end else if (capture && room) begin
      idx_reg <= idx_reg + 4'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] lane_reg;

      always_ff @(posedge clk) begin
        if (srst || clear) begin
          lane_reg <= 8'h00;
        end else if (capture && room && (idx_reg == 4'(gi))) begin
          lane_reg <= byte_in;
        end
      end

      assign data[8*gi +: 8] = lane_reg;
    end
  endgenerate

endmodule

// File: rtl/rand_req_host.sv
// Initiator for the byte-serial CPU random-number interface. Optional statistics
// outputs are enabled by defining RAND_REQ_HOST_STATS_EN.
module rand_req_host
  import rand_req_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_type,
  output logic        rand_req,
  output logic [2:0]  rand_req_type,
  input  logic [7:0]  rand_byte,
  input  logic        rand_valid,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_ok
`ifdef RAND_REQ_HOST_STATS_EN
  ,
  output logic [15:0] stat_done,
  output logic [15:0] stat_timeout,
  output logic [15:0] stat_stray
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

  state_e         state_reg, state_next;
  rand_req_t      type_reg;
  rand_req_t      cmd_req;
  logic [TW-1:0]  timer_reg;
  logic [GW-1:0]  gap_reg;
  logic           ok_reg;
  logic           rand_req_reg;
  logic           cmd_fire;
  logic           capture;
  logic           byte_last;
  logic           timeout_hit;
  logic [3:0]     nbytes;

  assign cmd_req     = rand_req_t'(cmd_type);
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign capture     = (state_reg == ST_REQ) && rand_valid;
  // A byte on the expiry cycle takes priority over the abort.
  assign timeout_hit = (state_reg == ST_REQ) && !rand_valid && (timer_reg == TIMER_LAST);
  assign nbytes      = req_bytes(type_reg.size);

  rand_byte_assembler u_asm (
    .clk     (clk),
    .srst    (rst),
    .clear   (cmd_fire),
    .capture (capture),
    .byte_in (rand_byte),
    .nbytes  (nbytes),
    .data    (rsp_data),
    .last    (byte_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_fire) begin
          state_next = (req_bytes(cmd_req.size) == 4'd0) ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        if (byte_last || timeout_hit) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_reg == GAP_LAST) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_reg == ST_IDLE) && !rst;
    rsp_valid = (state_reg == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      type_reg     <= '0;
      timer_reg    <= '0;
      gap_reg      <= '0;
      ok_reg       <= 1'b0;
      rand_req_reg <= 1'b0;
    end else begin
      // Registered so the request drops the cycle after the final byte.
      rand_req_reg <= (state_next == ST_REQ);
      if (cmd_fire) begin
        type_reg  <= cmd_req;
        timer_reg <= '0;
        ok_reg    <= 1'b0;
      end else if (capture) begin
        timer_reg <= '0;
      end else if (state_reg == ST_REQ) begin
        timer_reg <= timer_reg + 1'b1;
      end
      if (byte_last) begin
        ok_reg <= 1'b1;
      end
      gap_reg <= (state_reg == ST_GAP) ? gap_reg + 1'b1 : '0;
    end
  end

  assign rand_req      = rand_req_reg;
  assign rand_req_type = type_reg;
  assign rsp_ok        = ok_reg;

`ifdef RAND_REQ_HOST_STATS_EN
  logic [15:0] stat_done_reg, stat_timeout_reg, stat_stray_reg;
  logic        resp_entry;

  assign resp_entry = (state_reg != ST_RESP) && (state_next == ST_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_done_reg    <= '0;
      stat_timeout_reg <= '0;
      stat_stray_reg   <= '0;
    end else begin
      if (resp_entry && byte_last && (stat_done_reg != 16'hFFFF)) begin
        stat_done_reg <= stat_done_reg + 16'd1;
      end
      if (resp_entry && !byte_last && (stat_timeout_reg != 16'hFFFF)) begin
        stat_timeout_reg <= stat_timeout_reg + 16'd1;
      end
      if (rand_valid && (state_reg != ST_REQ) && (stat_stray_reg != 16'hFFFF)) begin
        stat_stray_reg <= stat_stray_reg + 16'd1;
      end
    end
  end

  assign stat_done    = stat_done_reg;
  assign stat_timeout = stat_timeout_reg;
  assign stat_stray   = stat_stray_reg;
`endif

endmodule
